// File: rtl/fft_cmd_seq_pkg.sv
// Shared encodings for the FFT command sequencer: R-type opcode/funct3, every
// FFT/IFFT funct7 code, FSM state and phase types.
package fft_cmd_seq_pkg;

  localparam logic [6:0] OPCODE_FFT = 7'h33;
  localparam logic [2:0] FUNCT3_FFT = 3'h0;

  localparam logic [6:0] F7_LOAD0 = 7'h10;
  localparam logic [6:0] F7_LOAD1 = 7'h11;
  localparam logic [6:0] F7_LOAD2 = 7'h12;
  localparam logic [6:0] F7_LOAD3 = 7'h13;
  localparam logic [6:0] F7_LOAD4 = 7'h14;
  localparam logic [6:0] F7_LOAD5 = 7'h15;
  localparam logic [6:0] F7_LOAD6 = 7'h16;
  localparam logic [6:0] F7_LOAD7 = 7'h17;

  localparam logic [6:0] F7_CAL1  = 7'h18;
  localparam logic [6:0] F7_CAL2  = 7'h19;
  localparam logic [6:0] F7_CAL3  = 7'h1A;
  localparam logic [6:0] F7_ICAL1 = 7'h2C;
  localparam logic [6:0] F7_ICAL2 = 7'h2D;
  localparam logic [6:0] F7_ICAL3 = 7'h2E;

  // 7'h20 is reserved by the ALU decode, so the export codes skip it.
  localparam logic [6:0] F7_EXP0_RE = 7'h1B;
  localparam logic [6:0] F7_EXP0_IM = 7'h1C;
  localparam logic [6:0] F7_EXP1_RE = 7'h1D;
  localparam logic [6:0] F7_EXP1_IM = 7'h1E;
  localparam logic [6:0] F7_EXP2_RE = 7'h1F;
  localparam logic [6:0] F7_EXP2_IM = 7'h21;
  localparam logic [6:0] F7_EXP3_RE = 7'h22;
  localparam logic [6:0] F7_EXP3_IM = 7'h23;
  localparam logic [6:0] F7_EXP4_RE = 7'h24;
  localparam logic [6:0] F7_EXP4_IM = 7'h25;
  localparam logic [6:0] F7_EXP5_RE = 7'h26;
  localparam logic [6:0] F7_EXP5_IM = 7'h27;
  localparam logic [6:0] F7_EXP6_RE = 7'h28;
  localparam logic [6:0] F7_EXP6_IM = 7'h29;
  localparam logic [6:0] F7_EXP7_RE = 7'h2A;
  localparam logic [6:0] F7_EXP7_IM = 7'h2B;

  localparam logic [3:0] LOAD_LAST   = 4'd7;
  localparam logic [3:0] CAL_LAST    = 4'd2;
  localparam logic [3:0] EXPORT_LAST = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAL,
    ST_EXPORT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_LOAD,
    PH_CAL,
    PH_EXPORT,
    PH_NONE
  } phase_t;

  function automatic logic [31:0] rtype_word(input logic [6:0] funct7,
                                             input logic [4:0] rs2,
                                             input logic [4:0] rs1,
                                             input logic [4:0] rd);
    return {funct7, rs2, rs1, FUNCT3_FFT, rd, OPCODE_FFT};
  endfunction

endpackage

// File: rtl/fft_cmd_seq_if.sv
// Command/issue bus between the FFT sequencer (slave) and its controller plus
// the downstream issue stage (master).
interface fft_cmd_seq_if;
  logic        start;
  logic        inverse;
  logic [4:0]  src_base;
  logic [4:0]  dst_base;
  logic        abort;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        done;

  modport slave (
    input  start, inverse, src_base, dst_base, abort, instr_ready,
    output instr, instr_valid, busy, done
  );

  modport master (
    output start, inverse, src_base, dst_base, abort, instr_ready,
    input  instr, instr_valid, busy, done
  );
endinterface

// File: rtl/fft_cmd_seq_funct7_rom.sv
// Combinational funct7 lookup: phase + index within phase (+ inverse for CAL).
import fft_cmd_seq_pkg::*;

module fft_funct7_rom (
  input  phase_t     i_phase,
  input  logic [3:0] i_index,
  input  logic       i_inverse,
  output logic [6:0] o_funct7
);

  always_comb begin
    o_funct7 = '0;
    case (i_phase)
      PH_LOAD: begin
        case (i_index[2:0])
          3'd0:    o_funct7 = F7_LOAD0;
          3'd1:    o_funct7 = F7_LOAD1;
          3'd2:    o_funct7 = F7_LOAD2;
          3'd3:    o_funct7 = F7_LOAD3;
          3'd4:    o_funct7 = F7_LOAD4;
          3'd5:    o_funct7 = F7_LOAD5;
          3'd6:    o_funct7 = F7_LOAD6;
          default: o_funct7 = F7_LOAD7;
        endcase
      end
      PH_CAL: begin
        case (i_index[1:0])
          2'd0:    o_funct7 = i_inverse ? F7_ICAL1 : F7_CAL1;
          2'd1:    o_funct7 = i_inverse ? F7_ICAL2 : F7_CAL2;
          2'd2:    o_funct7 = i_inverse ? F7_ICAL3 : F7_CAL3;
          default: o_funct7 = '0;
        endcase
      end
      PH_EXPORT: begin
        case (i_index)
          4'd0:    o_funct7 = F7_EXP0_RE;
          4'd1:    o_funct7 = F7_EXP0_IM;
          4'd2:    o_funct7 = F7_EXP1_RE;
          4'd3:    o_funct7 = F7_EXP1_IM;
          4'd4:    o_funct7 = F7_EXP2_RE;
          4'd5:    o_funct7 = F7_EXP2_IM;
          4'd6:    o_funct7 = F7_EXP3_RE;
          4'd7:    o_funct7 = F7_EXP3_IM;
          4'd8:    o_funct7 = F7_EXP4_RE;
          4'd9:    o_funct7 = F7_EXP4_IM;
          4'd10:   o_funct7 = F7_EXP5_RE;
          4'd11:   o_funct7 = F7_EXP5_IM;
          4'd12:   o_funct7 = F7_EXP6_RE;
          4'd13:   o_funct7 = F7_EXP6_IM;
          4'd14:   o_funct7 = F7_EXP7_RE;
          default: o_funct7 = F7_EXP7_IM;
        endcase
      end
      default: o_funct7 = '0;
    endcase
  end

endmodule

// File: rtl/fft_cmd_seq.sv
// FFT command sequencer: on start, issues 8 LOAD, 3 CAL and 16 EXPORT R-type
// words over a valid/ready handshake, then pulses done.
import fft_cmd_seq_pkg::*;

module fft_cmd_seq (
  input  logic          clk,
  input  logic          rst_n,
  fft_cmd_seq_if.slave  bus
);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_index;
  logic [3:0]  w_index_next;
  logic        r_inverse;
  logic [4:0]  r_src_base;
  logic [4:0]  r_dst_base;
  logic        w_capture;
  logic        w_valid;
  logic        w_handshake;
  phase_t      w_phase;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inverse  <= 1'b0;
      r_src_base <= '0;
      r_dst_base <= '0;
    end else if (w_capture) begin
      r_inverse  <= bus.inverse;
      r_src_base <= bus.src_base;
      r_dst_base <= bus.dst_base;
    end
  end

  assign w_valid     = (r_state == ST_LOAD) || (r_state == ST_CAL) || (r_state == ST_EXPORT);
  assign w_handshake = w_valid && bus.instr_ready;

  // Abort wins over any handshake presented in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_capture    = 1'b0;
    if ((r_state != ST_IDLE) && bus.abort) begin
      w_state_next = ST_IDLE;
      w_index_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_state_next = ST_LOAD;
            w_index_next = '0;
            w_capture    = 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_handshake) begin
            if (r_index == LOAD_LAST) begin
              w_state_next = ST_CAL;
              w_index_next = '0;
            end else begin
              w_index_next = r_index + 4'd1;
            end
          end
        end
        ST_CAL: begin
          if (w_handshake) begin
            if (r_index == CAL_LAST) begin
              w_state_next = ST_EXPORT;
              w_index_next = '0;
            end else begin
              w_index_next = r_index + 4'd1;
            end
          end
        end
        ST_EXPORT: begin
          if (w_handshake) begin
            if (r_index == EXPORT_LAST) begin
              w_state_next = ST_DONE;
              w_index_next = '0;
            end else begin
              w_index_next = r_index + 4'd1;
            end
          end
        end
        ST_DONE: begin
          w_state_next = ST_IDLE;
          w_index_next = '0;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_index_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_phase = PH_NONE;
    case (r_state)
      ST_LOAD:   w_phase = PH_LOAD;
      ST_CAL:    w_phase = PH_CAL;
      ST_EXPORT: w_phase = PH_EXPORT;
      default:   w_phase = PH_NONE;
    endcase
  end

  fft_funct7_rom u_rom (
    .i_phase   (w_phase),
    .i_index   (r_index),
    .i_inverse (r_inverse),
    .o_funct7  (w_funct7)
  );

  // Register indices wrap naturally in the 5-bit adders.
  assign w_rs1 = (r_state == ST_LOAD)   ? (r_src_base + {1'b0, r_index}) : 5'd0;
  assign w_rd  = (r_state == ST_EXPORT) ? (r_dst_base + {1'b0, r_index}) : 5'd0;

  assign bus.instr       = w_valid ? rtype_word(w_funct7, 5'd0, w_rs1, w_rd) : 32'd0;
  assign bus.instr_valid = w_valid;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_fft_cmd_seq.sv
// Randomized bench for fft_cmd_seq against a per-word arithmetic reference of
// the 27-word LOAD/CAL/EXPORT program.
module tb_fft_cmd_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] got [27];

  fft_cmd_seq_if u_if ();

  fft_cmd_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Word k of the program, straight from the encoding rules.
  function automatic logic [31:0] model_word(input int k, input logic inv,
                                             input logic [4:0] src, input logic [4:0] dst);
    int f7, rs1, rd, e;
    rs1 = 0;
    rd  = 0;
    if (k < 8) begin
      f7  = 'h10 + k;
      rs1 = (int'(src) + k) % 32;
    end else if (k < 11) begin
      f7 = inv ? ('h2B + (k - 7)) : ('h17 + (k - 7));
    end else begin
      e  = k - 11;
      f7 = (e < 5) ? ('h1B + e) : ('h1C + e);
      rd = (int'(dst) + e) % 32;
    end
    return 32'((f7 << 25) | (rs1 << 15) | (rd << 7) | 'h33);
  endfunction

  // mode 0: full run; mode 1: abort when word stop_at is offered; mode 2: reset there.
  task automatic run_seq(input logic inv, input logic [4:0] src, input logic [4:0] dst,
                         input int max_stall, input bit junk, input int mode, input int stop_at);
    logic [31:0] exp_q [27];
    logic [31:0] prev_instr;
    bit          prev_stalled;
    bit          stopped;
    int          n, cyc, vcyc, stall_left;
    for (int k = 0; k < 27; k++) exp_q[k] = model_word(k, inv, src, dst);
    @(negedge clk);
    u_if.start = 1'b1; u_if.inverse = inv; u_if.src_base = src; u_if.dst_base = dst;
    u_if.instr_ready = 1'b0;
    @(negedge clk);
    u_if.start = 1'b0;
    check("first_valid", 32'(u_if.instr_valid), 32'd1);
    check("busy_run", 32'(u_if.busy), 32'd1);
    n = 0; cyc = 0; vcyc = 0; prev_stalled = 0; stopped = 0; prev_instr = '0;
    stall_left = $urandom_range(0, max_stall);
    while (n < 27 && cyc < 600) begin
      if (junk) begin
        u_if.start    = ($urandom % 4 == 0);
        u_if.inverse  = 1'($urandom);
        u_if.src_base = 5'($urandom);
        u_if.dst_base = 5'($urandom);
      end
      check("valid_run", 32'(u_if.instr_valid), 32'd1);
      check("done_low", 32'(u_if.done), 32'd0);
      if (prev_stalled) check("stall_hold", u_if.instr, prev_instr);
      if (u_if.instr_valid) vcyc++;
      if (mode != 0 && n == stop_at) begin
        stopped = 1;
        break;
      end
      u_if.instr_ready = (stall_left == 0);
      if (u_if.instr_valid && u_if.instr_ready) begin
        check("word", u_if.instr, exp_q[n]);
        got[n] = u_if.instr;
        n++;
        stall_left   = $urandom_range(0, max_stall);
        prev_stalled = 0;
      end else begin
        if (u_if.instr_valid && stall_left > 0) stall_left--;
        prev_stalled = u_if.instr_valid;
      end
      prev_instr = u_if.instr;
      @(negedge clk);
      cyc++;
    end
    if (!stopped) begin
      check("count", 32'(n), 32'd27);
      if (max_stall == 0) check("span", 32'(vcyc), 32'd27);
      check("done_pulse", 32'(u_if.done), 32'd1);
      check("done_valid", 32'(u_if.instr_valid), 32'd0);
      check("done_instr", u_if.instr, 32'd0);
      u_if.start = junk;
      @(negedge clk);
      u_if.start = 1'b0;
      check("done_once", 32'(u_if.done), 32'd0);
      check("idle_busy", 32'(u_if.busy), 32'd0);
      check("idle_valid", 32'(u_if.instr_valid), 32'd0);
    end else if (mode == 1) begin
      check("abort_word", u_if.instr, exp_q[n]);
      u_if.start = 1'b0; u_if.abort = 1'b1; u_if.instr_ready = 1'b1;
      @(negedge clk);
      u_if.abort = 1'b0;
      check("abort_valid", 32'(u_if.instr_valid), 32'd0);
      check("abort_instr", u_if.instr, 32'd0);
      check("abort_busy", 32'(u_if.busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
        check("abort_done", 32'(u_if.done), 32'd0);
        @(negedge clk);
      end
    end else begin
      u_if.start = 1'b0; u_if.instr_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_instr", u_if.instr, 32'd0);
      check("rst_valid", 32'(u_if.instr_valid), 32'd0);
      check("rst_busy", 32'(u_if.busy), 32'd0);
      check("rst_done", 32'(u_if.done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("post_rst_done", 32'(u_if.done), 32'd0);
        check("post_rst_busy", 32'(u_if.busy), 32'd0);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    u_if.start = 1'b0; u_if.inverse = 1'b0; u_if.src_base = '0; u_if.dst_base = '0;
    u_if.abort = 1'b0; u_if.instr_ready = 1'b0;
    @(negedge clk);
    check("reset_instr", u_if.instr, 32'd0);
    check("reset_valid", 32'(u_if.instr_valid), 32'd0);
    check("reset_busy", 32'(u_if.busy), 32'd0);
    check("reset_done", 32'(u_if.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_seq(1'b0, 5'd10, 5'd5, 0, 1'b0, 0, 0);
    check("load0_src10", got[0], 32'h20050033);
    check("cal1_fwd", got[8], 32'h30000033);
    check("export0_dst5", got[11], 32'h360002B3);

    run_seq(1'b1, 5'($urandom), 5'd20, 0, 1'b0, 0, 0);
    check("ical1", got[8], 32'h58000033);
    check("ical2", got[9], 32'h5A000033);
    check("ical3", got[10], 32'h5C000033);
    check("export15_f7", 32'(got[26][31:25]), 32'h2B);
    check("export15_rd", 32'(got[26][11:7]), 32'd3);

    for (int r = 0; r < 4; r++)
      run_seq(1'($urandom), 5'($urandom), 5'($urandom), 5, 1'b1, 0, 0);

    run_seq(1'($urandom), 5'($urandom), 5'($urandom), 0, 1'b0, 1, 15);
    run_seq(1'($urandom), 5'($urandom), 5'($urandom), 2, 1'b0, 0, 0);

    run_seq(1'b0, 5'($urandom), 5'($urandom), 0, 1'b0, 2, 9);
    run_seq(1'b1, 5'd31, 5'd31, 3, 1'b1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
